// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-controller bundle: instruction-memory read channel, decoder issue channel
// and branch redirect. master = fetch controller, slave = memory/decoder side.
interface inst_fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        dec_valid;
   logic        dec_ready;
   logic [15:0] ir_q0;
   logic [14:0] ir_q1;
   logic        ir_is32;
   logic [31:0] ir_pc;
   logic        br_taken;
   logic [31:0] br_target;

   modport master (
      output imem_req, imem_addr, dec_valid, ir_q0, ir_q1, ir_is32, ir_pc,
      input  imem_ack, imem_rdata, dec_ready, br_taken, br_target
   );

   modport slave (
      input  imem_req, imem_addr, dec_valid, ir_q0, ir_q1, ir_is32, ir_pc,
      output imem_ack, imem_rdata, dec_ready, br_taken, br_target
   );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Thumb fetch sequencer: halfword reads into a small queue, 16/32-bit instruction
// assembly for the decoder, and branch redirect with discard of an in-flight read.
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          Q_DEPTH  = 4
) (
   input  logic clk,
   input  logic rst,
   inst_fetch_ctrl_if.master bus
);
   localparam int AW = $clog2(Q_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [31:0] PC0 = RESET_PC & ~32'd1;

   typedef enum logic {IDLE, REQ} state_t;

   state_t        state_reg, state_next;
   logic [15:0]   q_mem [Q_DEPTH];
   logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [CW-1:0] count_reg, count_next;
   logic [31:0]   addr_reg, addr_next;
   logic [31:0]   redirect_reg, redirect_next;
   logic [31:0]   pc_reg;
   logic          drop_reg, drop_next;
   logic [31:0]   br_addr;
   logic [15:0]   h0, h1;
   logic          h0_is32, valid, ack_fire, push, pop;
   logic [1:0]    popcnt;

   assign br_addr  = bus.br_target & ~32'd1;
   assign h0       = q_mem[rd_ptr_reg];
   assign h1       = q_mem[rd_ptr_reg + AW'(1)];
   assign h0_is32  = (h0[15:13] == 3'b111) && (h0[12:11] != 2'b00);
   assign valid    = ((count_reg >= CW'(1)) && !h0_is32) ||
                     ((count_reg >= CW'(2)) && h0_is32);
   assign popcnt   = h0_is32 ? 2'd2 : 2'd1;
   assign ack_fire = (state_reg == REQ) && bus.imem_ack;
   // Data returned for a pre-redirect address is discarded, never queued.
   assign push     = ack_fire && !drop_reg && !bus.br_taken;
   assign pop      = valid && bus.dec_ready && !bus.br_taken;

   assign bus.imem_req  = (state_reg == REQ);
   assign bus.imem_addr = addr_reg;
   assign bus.dec_valid = valid;
   assign bus.ir_pc     = pc_reg;
   assign bus.ir_q0     = (count_reg != '0) ? h0 : 16'h0000;
   assign bus.ir_is32   = (count_reg != '0) && h0_is32;
   assign bus.ir_q1     = (valid && h0_is32) ? 15'(h1 >> 1) : 15'h0000;

   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      drop_next     = drop_reg;
      redirect_next = redirect_reg;
      case (state_reg)
         IDLE: begin
            if (count_reg < CW'(Q_DEPTH))
               state_next = REQ;
            if (bus.br_taken)
               addr_next = br_addr;
         end
         REQ: begin
            if (ack_fire) begin
               state_next = IDLE;
               drop_next  = 1'b0;
               if (bus.br_taken)
                  addr_next = br_addr;
               else if (drop_reg)
                  addr_next = redirect_reg;
               else
                  addr_next = addr_reg + 32'd2;
            end else if (bus.br_taken) begin
               // Request stays on the bus; remember where to go once it completes.
               drop_next     = 1'b1;
               redirect_next = br_addr;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      count_next = count_reg + CW'(push) - (pop ? CW'(popcnt) : CW'(0));
      if (bus.br_taken)
         count_next = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         addr_reg     <= PC0;
         redirect_reg <= PC0;
         pc_reg       <= PC0;
         drop_reg     <= 1'b0;
         count_reg    <= '0;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         redirect_reg <= redirect_next;
         drop_reg     <= drop_next;
         count_reg    <= count_next;
         if (bus.br_taken) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            pc_reg     <= br_addr;
         end else begin
            if (push)
               wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop) begin
               rd_ptr_reg <= rd_ptr_reg + AW'(popcnt);
               pc_reg     <= pc_reg + (h0_is32 ? 32'd4 : 32'd2);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         q_mem[wr_ptr_reg] <= bus.imem_rdata;
   end
endmodule
